// File: rtl/rshiftreg_sipo_if.sv
// Bit-serial receive link plus valid/ready word output for rshiftreg_sipo.
// The master drives the serial bits and the ready signal. The slave (the deserializer) drives the word side.
interface rshiftreg_sipo_if #(
    parameter int n = 20
);
    logic         shift_in;
    logic         enable;
    logic         start;
    logic [n-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;

    modport master (
        output shift_in,
        output enable,
        output start,
        output out_ready,
        input  Y,
        input  out_valid,
        input  overrun
    );

    modport slave (
        input  shift_in,
        input  enable,
        input  start,
        input  out_ready,
        output Y,
        output out_valid,
        output overrun
    );
endinterface

// File: rtl/rshiftreg_sipo.sv
// Serial-in parallel-out deserializer (LSB first) with a one-entry valid/ready output register.
// Define RSHIFTREG_SIPO_OVERRUN_EN to drop words that arrive while the output is full, and to flag that case.
module rshiftreg_sipo #(
    parameter int n = 20
) (
    input  logic             clk,
    input  logic             reset,
    rshiftreg_sipo_if.slave  bus
);
    localparam int CNT_W = $clog2(n);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_t;

    logic [n-1:0]     r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [n-1:0]     r_y;
    outState_t        r_state;

    logic             w_lastBit;
    logic             w_wordDone;
    logic [n-1:0]     w_word;

    // A start pulse always begins a fresh frame, so it can never complete a word itself.
    assign w_lastBit  = (r_cnt == CNT_W'(n - 1));
    assign w_wordDone = bus.enable & ~bus.start & w_lastBit;
    assign w_word     = n'({bus.shift_in, r_sr} >> 1);

    // Assembly path: right shift that mirrors the transmitter, with frame restart on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (bus.start) begin
            if (bus.enable) begin
                r_sr  <= {bus.shift_in, {(n-1){1'b0}}};
                r_cnt <= CNT_W'(1);
            end else begin
                r_sr  <= '0;
                r_cnt <= '0;
            end
        end else if (bus.enable) begin
            if (w_lastBit) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else begin
                r_sr  <= w_word;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef RSHIFTREG_SIPO_OVERRUN_EN
    logic r_overrun;

    // Output register: a word that finds the register full and unaccepted is dropped, and the sticky flag is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y       <= '0;
            r_state   <= EMPTY;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_wordDone) begin
                        r_y     <= w_word;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_wordDone && !bus.out_ready) begin
                        r_overrun <= 1'b1;
                    end else if (w_wordDone) begin
                        r_y <= w_word;
                    end else if (bus.out_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.overrun = r_overrun;
`else
    // Output register: the newest completed word always wins, even if the previous one was not consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y     <= '0;
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_wordDone) begin
                        r_y     <= w_word;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_wordDone) begin
                        r_y <= w_word;
                    end else if (bus.out_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.overrun = 1'b0;
`endif

    assign bus.Y         = r_y;
    assign bus.out_valid = (r_state == FULL);
endmodule

// File: tb/tb_rshiftreg_sipo.sv
// Self-checking bench for rshiftreg_sipo. Expected words are queued when serial stimulus is driven.
// Each queued word is popped and compared when the DUT presents a completed word.
module tb_rshiftreg_sipo;
    localparam int N = 20;

    logic clk;
    logic reset;

    int vectorCount;
    int missCount;

    logic [N-1:0] expQ[$];

    rshiftreg_sipo_if #(.n(N)) bus ();

    rshiftreg_sipo #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock with a 10 ns period. Inputs change on the falling edge and outputs are sampled there too.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: keeps a stuck run from hanging.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkWord(input string tag);
        logic [N-1:0] exp;
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_qsize"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() != 0) begin
            exp = expQ.pop_front();
            checkOutput({tag, "_y"}, 32'(bus.Y), 32'(exp));
        end
    endtask

    // Drives one word, LSB first. Optionally inserts random idle gaps, raises start on bit 0,
    // or raises out_ready on the last bit only.
    task automatic applyStimulus(input logic [N-1:0] word, input bit gaps, input bit endIdle,
                                 input bit startFirst, input bit readyOnLast);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    @(negedge clk);
                    bus.enable    = 1'b0;
                    bus.start     = 1'b0;
                    bus.out_ready = 1'b0;
                    bus.shift_in  = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            bus.shift_in  = word[i];
            bus.enable    = 1'b1;
            bus.start     = startFirst && (i == 0);
            bus.out_ready = readyOnLast && (i == N - 1);
        end
        if (endIdle) begin
            @(negedge clk);
            bus.shift_in  = 1'b0;
            bus.enable    = 1'b0;
            bus.start     = 1'b0;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic sendJunkBits(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            bus.shift_in = 1'($urandom_range(0, 1));
            bus.enable   = 1'b1;
            bus.start    = 1'b0;
        end
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    task automatic drainOutput(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.shift_in  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
    endtask

    initial begin
        logic [N-1:0] rw;
        vectorCount   = 0;
        missCount     = 0;
        reset         = 1'b1;
        bus.shift_in  = 1'b0;
        bus.enable    = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_y",       32'(bus.Y),         32'd0);
        checkOutput("rst_valid",   32'(bus.out_valid), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun),   32'd0);
        reset = 1'b0;

        $display("[TB] alternating word, continuous enable");
        expQ.push_back(20'hAAAAA);
        applyStimulus(20'hAAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWord("t1");
        checkOutput("t1_overrun", 32'(bus.overrun), 32'd0);
        drainOutput("t1");

        $display("[TB] alternating word, random enable gaps");
        expQ.push_back(20'hAAAAA);
        applyStimulus(20'hAAAAA, 1'b1, 1'b1, 1'b0, 1'b0);
        checkWord("t2");
        drainOutput("t2");

        $display("[TB] single ready pulse, then ready while empty");
        expQ.push_back(20'h55555);
        applyStimulus(20'h55555, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWord("t3");
        drainOutput("t3_first");
        checkOutput("t3_hold_y", 32'(bus.Y), 32'h55555);
        drainOutput("t3_second");
        checkOutput("t3_empty_y",       32'(bus.Y),       32'h55555);
        checkOutput("t3_empty_overrun", 32'(bus.overrun), 32'd0);

        $display("[TB] back-to-back words with out_ready low");
`ifdef RSHIFTREG_SIPO_OVERRUN_EN
        expQ.push_back(20'hAAAAA);
`else
        expQ.push_back(20'h55555);
`endif
        applyStimulus(20'hAAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(20'h55555, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWord("t4");
`ifdef RSHIFTREG_SIPO_OVERRUN_EN
        checkOutput("t4_overrun", 32'(bus.overrun), 32'd1);
`else
        checkOutput("t4_overrun", 32'(bus.overrun), 32'd0);
`endif
        applyReset();
        checkOutput("t4_rst_valid",   32'(bus.out_valid), 32'd0);
        checkOutput("t4_rst_overrun", 32'(bus.overrun),   32'd0);

        $display("[TB] back-to-back words with out_ready at second completion");
        expQ.push_back(20'h55555);
        applyStimulus(20'hAAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(20'h55555, 1'b0, 1'b1, 1'b0, 1'b1);
        checkWord("t4b");
        checkOutput("t4b_overrun", 32'(bus.overrun), 32'd0);
        drainOutput("t4b");

        $display("[TB] start restarts the frame mid-word");
        sendJunkBits(7);
        expQ.push_back(20'h12345);
        applyStimulus(20'h12345, 1'b0, 1'b1, 1'b1, 1'b0);
        checkWord("t5");

        $display("[TB] asynchronous reset mid-word with a word pending");
        sendJunkBits(10);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_y",       32'(bus.Y),         32'd0);
        checkOutput("t6_async_valid",   32'(bus.out_valid), 32'd0);
        checkOutput("t6_async_overrun", 32'(bus.overrun),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        expQ.push_back(20'hF0F0F);
        applyStimulus(20'hF0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWord("t6");
        drainOutput("t6");

        $display("[TB] random words with random enable gaps");
        for (int k = 0; k < 4; k++) begin
            rw = N'($urandom);
            expQ.push_back(rw);
            applyStimulus(rw, 1'b1, 1'b1, 1'b0, 1'b0);
            checkWord($sformatf("rand%0d", k));
            drainOutput($sformatf("rand%0d", k));
        end
        checkOutput("final_overrun", 32'(bus.overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/rshiftreg_sipo.md
# rshiftreg_sipo

Serial-in parallel-out deserializer: the receive end of the bit-serial link driven by the team's right-shift parallel-load register (`rshiftregne`). It collects `n` serial bits, presented LSB first and qualified by `enable`, into an `n`-bit word. It hands each completed word to the downstream FIR datapath through a one-entry valid/ready output register.

## Interface
Parameters:
- `n`, 20, word width in bits; legal range `n` ≥ 2.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `shift_in`  in  1  serial data bit; sampled only when `enable`=1.
- `enable`  in  1  bit strobe; one bit consumed per rising edge while high.
- `start`  in  1  frame sync; restarts word assembly from bit 0.
- `Y`  out  `n`  last completed word, LSB = first bit received.
- `out_valid`  out  1  `Y` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts `Y` at an edge where `out_valid`=1.
- `overrun`  out  1  sticky flag: a completed word found the output register full.

## Operation
- Internal state:
  - shift register `sr[n-1:0]`;
  - bit counter `cnt`, width `$clog2(n)`, range 0..n-1;
  - output register `Y`;
  - output state EMPTY / FULL, with `out_valid` = (state == FULL).
- Shift on `enable`=1: `sr <= {shift_in, sr[n-1:1]}`, `cnt <= cnt+1`. This mirrors the transmitter's right shift, so bit 0 sent first lands in `Y[0]`.
- Word completes when `enable`=1 and `cnt`=n-1:
  - assembled word = `{shift_in, sr[n-1:1]}`;
  - `cnt` wraps to 0;
  - `sr` is don't-care afterwards but must be cleared to 0.
- `enable`=0: `sr` and `cnt` hold.
- `start`=1:
  - with `enable`=0: `cnt <= 0`, `sr <= 0`;
  - with `enable`=1: the current bit is taken as bit 0 of the new frame, so `cnt <= 1` and `sr <= {shift_in, {n-1{1'b0}}}`;
  - never touches `Y`, `out_valid` or `overrun`.
- Output FSM:
  - EMPTY → FULL on word complete; `Y` loads the word.
  - FULL → EMPTY when `out_ready`=1 and no word completes in the same cycle.
  - FULL with `out_ready`=1 and a word completing in the same cycle: `Y` loads the new word, state stays FULL, no overrun.
  - FULL with `out_ready`=0 and a word completing: overrun case; see Configuration.
  - `out_ready` while EMPTY is ignored.
- `Y` is stable while `out_valid`=1 except for the loads listed above.

## Timing
- Reset values, applied asynchronously and held while `reset`=1: `sr`=0, `cnt`=0, `Y`=0, `out_valid`=0, `overrun`=0, state EMPTY.
- Latency: the n-th `enable` edge loads `Y` and raises `out_valid` at that same edge. Both are visible in the following cycle, so latency from the last bit sample is 1 clock.
- Throughput: one word per `n` enabled cycles. With `out_ready` tied high, back-to-back words never overrun.
- Acceptance (`out_valid`=1 and `out_ready`=1 at an edge) drops `out_valid` at that edge, unless a new word completes at the same edge.
- Reset asserted mid-word or mid-handshake discards everything. The first enabled bit after deassertion is bit 0.
- Inputs must be stable around the rising edge. `enable` may toggle every cycle, including random patterns.

## Configuration
- Macro: `RSHIFTREG_SIPO_OVERRUN_EN`.
- Defined:
  - on the overrun case the new word is dropped;
  - `Y` keeps the unconsumed word and `out_valid` stays 1;
  - `overrun` is set and stays 1 until `reset`.
- Not defined:
  - on the overrun case `Y` is overwritten with the new word (latest wins) and `out_valid` stays 1;
  - `overrun` is tied to 0.

## Test plan
1. Reset with `n`=20; check all outputs are 0. Send 20 enabled bits 0,1,0,1,… with `out_ready`=0 → `Y`=20'hAAAAA and `out_valid`=1 one clock after the 20th bit; `overrun`=0.
2. Send the same 20 bits with `enable` randomized 50% per cycle → `Y`=20'hAAAAA after exactly 20 enabled edges, independent of the gaps.
3. After a word 20'h55555 is pending, pulse `out_ready` for one cycle → `out_valid` falls at that edge and `Y` holds 20'h55555. A second `out_ready` pulse while EMPTY changes nothing.
4. Stream 20'hAAAAA then 20'h55555 back-to-back with `out_ready`=0:
   - macro defined: `Y`=20'hAAAAA and `overrun`=1;
   - macro undefined: `Y`=20'h55555 and `overrun`=0.
   Repeat with `out_ready`=1 asserted at the second completion edge → `Y`=20'h55555, `out_valid`=1, `overrun`=0.
5. Send 7 bits, then `start` together with `enable`, then 19 more bits of 20'h12345 (the `start` bit counts as bit 0) → `Y`=20'h12345.
6. Assert `reset` asynchronously after 10 bits with a word pending → all outputs go 0 immediately. Then send 20 bits of 20'hF0F0F → `Y`=20'hF0F0F.
